wm_input_conditioner: RTL and testbench

WM_INPUT_CONDITIONER -- requirements
Module: wm_input_conditioner

---
 rtl/wm_input_conditioner.sv | 223 ++++++++++++++++++++++
 tb/tb_wm_input_conditioner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_input_conditioner.sv
// Washing-machine input conditioner: raw switch sync/debounce,
// start-request edge detect and optional door interlock FSM.
//
// Optional feature macro: WM_DOOR_INTERLOCK_EN
//   defined   : door channel + interlock FSM, door_lock driven
//   undefined : door input ignored, door_lock tied 0,
//               start pulses on every start request
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a debounced change
//   LOCK_SETTLE      lock hold time before the start pulse
//   UNLOCK_DELAY     lock hold time after the cycle ends
// Ports:
//   clk, rst          clock, sync active-high reset
//   start_btn_raw     raw start button (async)
//   level_sensor_raw  raw water-level-full switch (async)
//   drain_sensor_raw  raw drain-empty switch (async)
//   door_closed_raw   raw door-closed switch (async)
//   machine_idle      controller idle (IDLE/END)
//   start             one-cycle start pulse
//   water_level_full  debounced level
//   drain_empty       debounced drain
//   door_lock         door solenoid, 1 = locked

module wm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCK_SETTLE     = 8,
  parameter int UNLOCK_DELAY    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn_raw,
  input  logic level_sensor_raw,
  input  logic drain_sensor_raw,
  input  logic door_closed_raw,
  input  logic machine_idle,
  output logic start,
  output logic water_level_full,
  output logic drain_empty,
  output logic door_lock
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

  // channel map: 0 start, 1 level, 2 drain, 3 door
`ifdef WM_DOOR_INTERLOCK_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] r_deb;
  logic [DW-1:0]  r_cnt [NCH];
  logic           r_start_q;
  logic           w_start_req;

  assign w_raw[0] = start_btn_raw;
  assign w_raw[1] = level_sensor_raw;
  assign w_raw[2] = drain_sensor_raw;
`ifdef WM_DOOR_INTERLOCK_EN
  assign w_raw[3] = door_closed_raw;
`endif

  // The debounced value changes on the edge after the
  // counter has already reached DB_MAX, giving a total
  // latency of 2 + DEBOUNCE_CYCLES from the raw edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      r_start_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_start_q <= r_deb[0];
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_MAX) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // rising edge only, so a held button never repeats
  assign w_start_req = r_deb[0] & ~r_start_q;

  assign water_level_full = r_deb[1];
  assign drain_empty      = r_deb[2];

`ifdef WM_DOOR_INTERLOCK_EN

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int CNT_MAX = (LOCK_SETTLE > UNLOCK_DELAY) ?
                           LOCK_SETTLE : UNLOCK_DELAY;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_SETTLE - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(UNLOCK_DELAY - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_tcnt;
  logic [CW-1:0] w_tcnt_nxt;
  logic          r_seen_busy;
  logic          w_seen_nxt;
  logic          r_start;
  logic          w_start_nxt;
  logic          r_lock;
  logic          w_door;

  assign w_door = r_deb[3];

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_seen_nxt  = r_seen_busy;
    w_start_nxt = 1'b0;
    case (r_state)
      UNLOCKED: begin
        w_tcnt_nxt = '0;
        w_seen_nxt = 1'b0;
        // request with door open is dropped, not held
        if (w_start_req && w_door) begin
          w_state_nxt = LOCKING;
        end
      end
      LOCKING: begin
        if (!w_door) begin
          w_state_nxt = UNLOCKED;
          w_tcnt_nxt  = '0;
        end else if (r_tcnt == SETTLE_LAST) begin
          w_state_nxt = LOCKED;
          w_tcnt_nxt  = '0;
          w_seen_nxt  = 1'b0;
          w_start_nxt = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      LOCKED: begin
        // leave only after the controller has been busy
        if (!machine_idle) begin
          w_seen_nxt = 1'b1;
        end else if (r_seen_busy) begin
          w_state_nxt = RELEASE;
          w_tcnt_nxt  = '0;
        end
      end
      RELEASE: begin
        if (r_tcnt == DELAY_LAST) begin
          w_state_nxt = UNLOCKED;
          w_tcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = UNLOCKED;
        w_tcnt_nxt  = '0;
        w_seen_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= UNLOCKED;
      r_tcnt      <= '0;
      r_seen_busy <= 1'b0;
      r_start     <= 1'b0;
      r_lock      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_seen_busy <= w_seen_nxt;
      r_start     <= w_start_nxt;
      r_lock      <= (w_state_nxt != UNLOCKED);
    end
  end

  assign start     = r_start;
  assign door_lock = r_lock;

`else

  logic r_start;
  logic w_unused;

  assign w_unused = ^{door_closed_raw, machine_idle,
                      32'(LOCK_SETTLE), 32'(UNLOCK_DELAY)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= 1'b0;
    end else begin
      r_start <= w_start_req;
    end
  end

  assign start     = r_start;
  assign door_lock = 1'b0;

`endif

endmodule

// File: tb/tb_wm_input_conditioner.sv
// Testbench for wm_input_conditioner: scoreboard of expected
// output transitions (edge, signal, value).

module tb_wm_input_conditioner;

  localparam int S_START = 0;
  localparam int S_LEVEL = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DOOR  = 3;

  logic clk;
  logic rst;
  logic start_btn_raw;
  logic level_sensor_raw;
  logic drain_sensor_raw;
  logic door_closed_raw;
  logic machine_idle;
  logic start;
  logic water_level_full;
  logic drain_empty;
  logic door_lock;

  wm_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .LOCK_SETTLE     (3),
    .UNLOCK_DELAY    (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_btn_raw    (start_btn_raw),
    .level_sensor_raw (level_sensor_raw),
    .drain_sensor_raw (drain_sensor_raw),
    .door_closed_raw  (door_closed_raw),
    .machine_idle     (machine_idle),
    .start            (start),
    .water_level_full (water_level_full),
    .drain_empty      (drain_empty),
    .door_lock        (door_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } ev_t;

  ev_t  exq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   edge_n = 0;
  bit   mon_en = 0;
  logic [3:0] prev;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(string tag, int c, int s, int v);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    exq.push_back(e);
  endtask

  task automatic expect_pulse(string tag, int c);
    expect_ev({tag, "_rise"}, c, S_START, 1);
    expect_ev({tag, "_fall"}, c + 1, S_START, 0);
  endtask

  // event code: edge*100 + signal*10 + value
  always @(negedge clk) begin
    logic [3:0] cur;
    ev_t        e;
    cur = {door_lock, drain_empty, water_level_full, start};
    if (mon_en) begin
      for (int s = 0; s < 4; s++) begin
        if (cur[s] !== prev[s]) begin
          if (exq.size() == 0) begin
            check("spurious", edge_n * 100 + s * 10 + 32'(cur[s]), 0);
          end else begin
            e = exq.pop_front();
            check(e.tag, edge_n * 100 + s * 10 + 32'(cur[s]),
                  e.cyc * 100 + e.sig * 10 + e.val);
          end
        end
      end
    end
    prev = cur;
  end

  initial begin
    int n;
    rst              = 1'b1;
    start_btn_raw    = 1'b0;
    level_sensor_raw = 1'b0;
    drain_sensor_raw = 1'b0;
    door_closed_raw  = 1'b0;
    machine_idle     = 1'b1;
    tick(3);
    check("rst_start", 32'(start), 0);
    check("rst_level", 32'(water_level_full), 0);
    check("rst_drain", 32'(drain_empty), 0);
    check("rst_lock", 32'(door_lock), 0);
    mon_en = 1;
    rst    = 1'b0;

    // level debounce, rise and fall
    n = edge_n + 1;
    level_sensor_raw = 1'b1;
    expect_ev("lvl_rise", n + 6, S_LEVEL, 1);
    tick(10);
    n = edge_n + 1;
    level_sensor_raw = 1'b0;
    expect_ev("lvl_fall", n + 6, S_LEVEL, 0);
    tick(10);

    // 3-cycle glitch must be filtered
    drain_sensor_raw = 1'b1;
    tick(3);
    drain_sensor_raw = 1'b0;
    tick(10);

    // 5-cycle pulse just passes
    n = edge_n + 1;
    drain_sensor_raw = 1'b1;
    expect_ev("drn_rise", n + 6, S_DRAIN, 1);
    expect_ev("drn_fall", n + 11, S_DRAIN, 0);
    tick(5);
    drain_sensor_raw = 1'b0;
    tick(12);

    // close door
    door_closed_raw = 1'b1;
    tick(12);

    // normal start, held button
    n = edge_n + 1;
    start_btn_raw = 1'b1;
`ifdef WM_DOOR_INTERLOCK_EN
    expect_ev("norm_lock", n + 7, S_DOOR, 1);
    expect_pulse("norm_start", n + 10);
`else
    expect_pulse("norm_start", n + 7);
`endif
    tick(14);
    start_btn_raw = 1'b0;
    tick(12);

    // second press while locked
    n = edge_n + 1;
    start_btn_raw = 1'b1;
`ifndef WM_DOOR_INTERLOCK_EN
    expect_pulse("press2", n + 7);
`endif
    tick(8);
    start_btn_raw = 1'b0;
    tick(12);

    // controller busy then idle -> release
    machine_idle = 1'b0;
    tick(3);
    n = edge_n + 1;
    machine_idle = 1'b1;
`ifdef WM_DOOR_INTERLOCK_EN
    expect_ev("release", n + 5, S_DOOR, 0);
`endif
    tick(12);

    // press with door open
    door_closed_raw = 1'b0;
    tick(12);
    n = edge_n + 1;
    start_btn_raw = 1'b1;
`ifndef WM_DOOR_INTERLOCK_EN
    expect_pulse("open_press", n + 7);
`endif
    tick(8);
    start_btn_raw = 1'b0;
    tick(12);

    // door opens during LOCKING
    door_closed_raw = 1'b1;
    tick(12);
    n = edge_n + 1;
    start_btn_raw = 1'b1;
`ifdef WM_DOOR_INTERLOCK_EN
    expect_ev("abort_lock", n + 7, S_DOOR, 1);
    expect_ev("abort_unlock", n + 9, S_DOOR, 0);
`else
    expect_pulse("abort_start", n + 7);
`endif
    tick(2);
    door_closed_raw = 1'b0;
    tick(6);
    start_btn_raw = 1'b0;
    tick(12);

    // request and door-open on the same cycle
    door_closed_raw = 1'b1;
    tick(12);
    n = edge_n + 1;
    start_btn_raw   = 1'b1;
    door_closed_raw = 1'b0;
`ifndef WM_DOOR_INTERLOCK_EN
    expect_pulse("same_cyc", n + 7);
`endif
    tick(8);
    start_btn_raw = 1'b0;
    tick(12);

    // reach LOCKED then reset
    door_closed_raw = 1'b1;
    tick(12);
    n = edge_n + 1;
    start_btn_raw = 1'b1;
`ifdef WM_DOOR_INTERLOCK_EN
    expect_ev("rl_lock", n + 7, S_DOOR, 1);
    expect_pulse("rl_start", n + 10);
`else
    expect_pulse("rl_start", n + 7);
`endif
    tick(8);
    start_btn_raw = 1'b0;
    tick(12);
    n = edge_n + 1;
    rst = 1'b1;
`ifdef WM_DOOR_INTERLOCK_EN
    expect_ev("rl_unlock", n, S_DOOR, 0);
`endif
    tick(1);
    check("rl_lock_now", 32'(door_lock), 0);
    check("rl_start_now", 32'(start), 0);
    rst = 1'b0;
    tick(12);

    // input already high across reset
    level_sensor_raw = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n = edge_n + 1;
    expect_ev("post_rst_lvl", n + 6, S_LEVEL, 1);
    tick(10);
    n = edge_n + 1;
    level_sensor_raw = 1'b0;
    expect_ev("post_rst_fall", n + 6, S_LEVEL, 0);
    tick(12);

    check("pending", 32'(exq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
